// File: rtl/tcp_tx_merge_pkg.sv
// Shared constants, state encoding and frame word builders for the
// multi-channel SiTCPXG transmit merger.
package tcp_tx_merge_pkg;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;
  localparam logic [15:0] TRL_MAGIC = 16'h5AA5;
  localparam logic [3:0]  TX_B_FULL = 4'd8;
  localparam logic [3:0]  TX_B_IDLE = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    TRL  = 2'd3
  } state_e;

  function automatic logic [63:0] hdr_word(input logic [7:0] ch, input logic [31:0] seq);
    return {HDR_MAGIC, ch, 8'h00, seq};
  endfunction

  function automatic logic [63:0] trl_word(input logic [7:0]  ch,
                                           input logic        trunc,
                                           input logic [15:0] wcnt);
    return {TRL_MAGIC, ch, 7'b0, trunc, 16'h0000, wcnt};
  endfunction

endpackage

// File: rtl/tcp_tx_merge_rr_arbiter.sv
// Round-robin arbiter: the search starts at the channel after the last
// one granted; the pointer only moves on an accepted grant (adv).
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: channels at/after the pointer first, then wrap to the rest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr_q)) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
    if (!en) begin
      found = 1'b0;
    end
    gnt = '0;
    if (found) begin
      gnt[idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (adv && found) begin
      ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tcp_tx_merge.sv
// Merges NUM_CH 64-bit block streams into one SiTCPXG TX port, framing each
// block with a header (channel, sequence) and a trailer (truncation, count).
module tcp_tx_merge
  import tcp_tx_merge_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MAX_BLK_WORDS = 1024
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic [NUM_CH-1:0]    CH_MASK,
  input  logic [NUM_CH-1:0]    CH_VALID,
  output logic [NUM_CH-1:0]    CH_READY,
  input  logic [NUM_CH*64-1:0] CH_DATA,
  input  logic [NUM_CH-1:0]    CH_LAST,
  input  logic                 TX_AFULL,
  output logic [63:0]          TX_D,
  output logic [3:0]           TX_B,
  output logic [31:0]          BLK_CNT,
  output logic [15:0]          TRUNC_CNT
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WW = $clog2(MAX_BLK_WORDS + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_BLK_WORDS);

  state_e        state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          trunc_q, trunc_d;
  logic [31:0]   seq_q [NUM_CH];
  logic [31:0]   seq_d [NUM_CH];
  logic [63:0]   tx_d_q, tx_d_d;
  logic [3:0]    tx_b_q, tx_b_d;
  logic [31:0]   blk_q, blk_d;
  logic [15:0]   trc_q, trc_d;

  logic [NUM_CH-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              arb_en;
  logic              arb_adv;
  logic [NUM_CH-1:0] ready;
  logic [WW-1:0]     wcnt_inc;
  logic [7:0]        ch_id;
  logic [63:0]       ch_word;

  assign arb_en   = (state_q == IDLE) && ENABLE && !TX_AFULL;
  assign wcnt_inc = wcnt_q + WW'(1);
  assign ch_id    = 8'(sel_q);
  assign ch_word  = CH_DATA[{sel_q, 6'd0} +: 64];

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .req   (CH_VALID & CH_MASK),
    .en    (arb_en),
    .adv   (arb_adv),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  // READY is combinational so a word is taken in the same cycle AFULL drops.
  always_comb begin
    ready = '0;
    if ((state_q == DATA) && !TX_AFULL) begin
      ready[sel_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wcnt_d  = wcnt_q;
    trunc_d = trunc_q;
    seq_d   = seq_q;
    tx_d_d  = tx_d_q;
    tx_b_d  = TX_B_IDLE;
    blk_d   = blk_q;
    trc_d   = trc_q;
    arb_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          sel_d   = gnt_idx;
          arb_adv = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!TX_AFULL) begin
          tx_d_d  = hdr_word(ch_id, seq_q[sel_q]);
          tx_b_d  = TX_B_FULL;
          state_d = DATA;
        end
      end
      DATA: begin
        if (CH_VALID[sel_q] && !TX_AFULL) begin
          tx_d_d = ch_word;
          tx_b_d = TX_B_FULL;
          wcnt_d = wcnt_inc;
          if (CH_LAST[sel_q]) begin
            state_d = TRL;
          end else if (wcnt_inc == WMAX) begin
            trunc_d = 1'b1;
            state_d = TRL;
          end
        end
      end
      TRL: begin
        if (!TX_AFULL) begin
          tx_d_d       = trl_word(ch_id, trunc_q, 16'(wcnt_q));
          tx_b_d       = TX_B_FULL;
          seq_d[sel_q] = seq_q[sel_q] + 32'd1;
          blk_d        = blk_q + 32'd1;
          if (trunc_q && (trc_q != 16'hFFFF)) begin
            trc_d = trc_q + 16'd1;
          end
          wcnt_d  = '0;
          trunc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wcnt_q  <= '0;
      trunc_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        seq_q[i] <= '0;
      end
      tx_d_q  <= '0;
      tx_b_q  <= TX_B_IDLE;
      blk_q   <= '0;
      trc_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
      trunc_q <= trunc_d;
      seq_q   <= seq_d;
      tx_d_q  <= tx_d_d;
      tx_b_q  <= tx_b_d;
      blk_q   <= blk_d;
      trc_q   <= trc_d;
    end
  end

  assign CH_READY  = ready;
  assign TX_D      = tx_d_q;
  assign TX_B      = tx_b_q;
  assign BLK_CNT   = blk_q;
  assign TRUNC_CNT = trc_q;

endmodule

// File: tb/tb_tcp_tx_merge.sv
// Self-checking bench: per-channel word queues feed the merger, and a frame
// parser checks the output stream against the framing rules.
module tb_tcp_tx_merge;

  localparam int unsigned NCH  = 4;
  localparam int unsigned MAXW = 4;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               ENABLE;
  logic [NCH-1:0]     CH_MASK;
  logic [NCH-1:0]     CH_VALID;
  logic [NCH-1:0]     CH_READY;
  logic [NCH*64-1:0]  CH_DATA;
  logic [NCH-1:0]     CH_LAST;
  logic               TX_AFULL;
  logic [63:0]        TX_D;
  logic [3:0]         TX_B;
  logic [31:0]        BLK_CNT;
  logic [15:0]        TRUNC_CNT;

  always #5 CLK = ~CLK;

  tcp_tx_merge #(
    .NUM_CH        (NCH),
    .MAX_BLK_WORDS (MAXW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ENABLE    (ENABLE),
    .CH_MASK   (CH_MASK),
    .CH_VALID  (CH_VALID),
    .CH_READY  (CH_READY),
    .CH_DATA   (CH_DATA),
    .CH_LAST   (CH_LAST),
    .TX_AFULL  (TX_AFULL),
    .TX_D      (TX_D),
    .TX_B      (TX_B),
    .BLK_CNT   (BLK_CNT),
    .TRUNC_CNT (TRUNC_CNT)
  );

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  word_t       drv_q [NCH][$];
  word_t       mon_q [NCH][$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned valid_pct = 100;
  logic [31:0] exp_seq [NCH];
  logic [31:0] exp_blk;
  logic [15:0] exp_tc;
  int          mon_phase;
  int          mon_ch;
  int          mon_cnt;
  int          last_hdr_ch;
  logic        exp_tb;
  logic        after_trl;
  logic [63:0] hdr_log [$];
  logic [63:0] trl_log [$];
  logic [67:0] trace [$];

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int ch, input logic [63:0] d, input logic last);
    word_t w;
    w.data = d;
    w.last = last;
    drv_q[ch].push_back(w);
    mon_q[ch].push_back(w);
  endtask

  task automatic gen_block(input int ch, input int len);
    for (int i = 0; i < len; i++) begin
      push_word(ch, {$urandom, $urandom}, (i == len - 1));
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) begin
      exp_seq[c] = '0;
      mon_q[c]   = drv_q[c];
    end
    exp_blk     = '0;
    exp_tc      = '0;
    mon_phase   = 0;
    mon_ch      = 0;
    mon_cnt     = 0;
    after_trl   = 1'b0;
    last_hdr_ch = NCH - 1;
  endtask

  function automatic bit idle_now();
    bit r;
    r = (mon_phase == 0);
    for (int c = 0; c < NCH; c++) begin
      if (drv_q[c].size() != 0 || mon_q[c].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  // Frame parser: header -> data words (until last or MAXW) -> trailer.
  task automatic monitor();
    logic [63:0] d;
    word_t       w;
    d = TX_D;
    trace.push_back({TX_B, TX_D});
    if (after_trl) begin
      chk("idle_after_trl", 68'(TX_B), 68'(0));
      after_trl = 1'b0;
    end
    if (TX_B !== 4'd8) begin
      if (TX_B !== 4'd0) chk("txb_code", 68'(TX_B), 68'(0));
      return;
    end
    case (mon_phase)
      0: begin
        chk("hdr_magic", 68'(d[63:48]), 68'(16'hA55A));
        chk("hdr_pad", 68'(d[39:32]), 68'(0));
        chk("hdr_ch_range", 68'(d[47:40] < 8'(NCH)), 68'(1));
        mon_ch = (d[47:40] < 8'(NCH)) ? int'(d[47:40]) : 0;
        chk("hdr_seq", 68'(d[31:0]), 68'(exp_seq[mon_ch]));
        hdr_log.push_back(d);
        last_hdr_ch = mon_ch;
        mon_cnt   = 0;
        mon_phase = 1;
      end
      1: begin
        chk("data_avail", 68'(mon_q[mon_ch].size() > 0), 68'(1));
        if (mon_q[mon_ch].size() > 0) begin
          w = mon_q[mon_ch].pop_front();
          chk("data", 68'(d), 68'(w.data));
          mon_cnt++;
          if (w.last || mon_cnt == MAXW) begin
            exp_tb    = !w.last;
            mon_phase = 2;
          end
        end
      end
      default: begin
        chk("trailer", 68'(d), 68'({16'h5AA5, 8'(mon_ch), 7'd0, exp_tb, 16'h0000, 16'(mon_cnt)}));
        trl_log.push_back(d);
        exp_seq[mon_ch] = exp_seq[mon_ch] + 32'd1;
        exp_blk = exp_blk + 32'd1;
        if (exp_tb && exp_tc != 16'hFFFF) exp_tc = exp_tc + 16'd1;
        chk("blk_cnt", 68'(BLK_CNT), 68'(exp_blk));
        chk("trunc_cnt", 68'(TRUNC_CNT), 68'(exp_tc));
        mon_phase = 0;
        after_trl = 1'b1;
      end
    endcase
  endtask

  // Entered at posedge+1: drive, sample handshakes before the edge, then parse.
  task automatic cycle();
    for (int c = 0; c < NCH; c++) begin
      if (drv_q[c].size() > 0 && $urandom_range(99) < valid_pct) begin
        CH_VALID[c]        = 1'b1;
        CH_DATA[c*64 +: 64] = drv_q[c][0].data;
        CH_LAST[c]         = drv_q[c][0].last;
      end else begin
        CH_VALID[c]        = 1'b0;
        CH_DATA[c*64 +: 64] = {$urandom, $urandom};
        CH_LAST[c]         = 1'($urandom_range(1));
      end
    end
    #3;
    if (TX_AFULL) chk("ready_afull", 68'(CH_READY), 68'(0));
    for (int c = 0; c < NCH; c++) begin
      if (CH_VALID[c] && CH_READY[c]) begin
        chk("hs_ch", 68'(c), 68'(mon_ch));
        chk("hs_phase", 68'(mon_phase), 68'(1));
        void'(drv_q[c].pop_front());
      end
    end
    @(posedge CLK);
    #1;
    monitor();
  endtask

  task automatic drain(input int unsigned lim);
    int unsigned n;
    bit done;
    n = 0;
    ENABLE = 1'b1;
    CH_MASK = '1;
    TX_AFULL = 1'b0;
    valid_pct = 100;
    done = idle_now();
    while (!done && n < lim) begin
      cycle();
      n++;
      done = idle_now();
    end
    cycle();
    chk("drain_done", 68'(done), 68'(1));
  endtask

  task automatic wait_phase(input int ph, input int min_cnt, input int unsigned lim, input string tag);
    int unsigned n;
    n = 0;
    while (!(mon_phase == ph && mon_cnt >= min_cnt) && n < lim) begin
      cycle();
      n++;
    end
    chk(tag, 68'(mon_phase == ph && mon_cnt >= min_cnt), 68'(1));
  endtask

  initial begin
    int          h;
    bit          found;
    int          prev;
    int unsigned n;

    RST_N = 1'b0;
    ENABLE = 1'b0;
    CH_MASK = '1;
    CH_VALID = '0;
    CH_DATA = '0;
    CH_LAST = '0;
    TX_AFULL = 1'b0;
    reset_model();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_txb", 68'(TX_B), 68'(0));
    chk("rst_txd", 68'(TX_D), 68'(0));
    chk("rst_ready", 68'(CH_READY), 68'(0));
    chk("rst_blk", 68'(BLK_CNT), 68'(0));
    chk("rst_trunc", 68'(TRUNC_CNT), 68'(0));
    RST_N = 1'b1;
    ENABLE = 1'b1;
    cycle();

    // Single channel, exact cycle-by-cycle output
    trace.delete();
    push_word(2, 64'h0123_4567_89AB_CDEF, 1'b0);
    push_word(2, 64'hFEDC_BA98_7654_3210, 1'b0);
    push_word(2, 64'h0F0F_1E1E_2D2D_3C3C, 1'b1);
    repeat (12) cycle();
    found = 1'b0;
    h = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (!found && trace[i][67:64] == 4'd8) begin
        found = 1'b1;
        h = i;
      end
    end
    chk("p1_hdr_found", 68'(found), 68'(1));
    if (found && h + 5 < trace.size()) begin
      chk("p1_hdr", trace[h],   {4'd8, 64'hA55A_0200_0000_0000});
      chk("p1_w0",  trace[h+1], {4'd8, 64'h0123_4567_89AB_CDEF});
      chk("p1_w1",  trace[h+2], {4'd8, 64'hFEDC_BA98_7654_3210});
      chk("p1_w2",  trace[h+3], {4'd8, 64'h0F0F_1E1E_2D2D_3C3C});
      chk("p1_trl", trace[h+4], {4'd8, 64'h5AA5_0200_0000_0003});
      chk("p1_idle", 68'(trace[h+5][67:64]), 68'(0));
    end
    chk("p1_blk", 68'(BLK_CNT), 68'(1));
    drain(20);

    // Round-robin fairness with 1-word blocks on every channel
    prev = last_hdr_ch;
    hdr_log.delete();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) gen_block(c, 1);
    end
    drain(200);
    chk("rr_count", 68'(hdr_log.size()), 68'(3 * NCH));
    foreach (hdr_log[i]) begin
      chk("rr_order", 68'(hdr_log[i][47:40]), 68'((prev + 1) % NCH));
      prev = int'(hdr_log[i][47:40]);
    end

    // Truncation: 6-word block against a 4-word limit
    trl_log.delete();
    gen_block(1, 6);
    drain(100);
    chk("p3_trl_count", 68'(trl_log.size()), 68'(2));
    if (trl_log.size() >= 2) begin
      chk("p3_trl0", 68'(trl_log[0]), 68'(64'h5AA5_0101_0000_0004));
      chk("p3_trl1", 68'(trl_log[1]), 68'(64'h5AA5_0100_0000_0002));
    end
    chk("p3_trunc_cnt", 68'(TRUNC_CNT), 68'(1));

    // Backpressure held for 10 cycles mid-DATA
    gen_block(3, 4);
    wait_phase(1, 1, 30, "p4_start");
    TX_AFULL = 1'b1;
    repeat (10) begin
      cycle();
      chk("bp_txb", 68'(TX_B), 68'(0));
    end
    TX_AFULL = 1'b0;
    drain(50);

    // Randomized traffic, backpressure and configuration churn
    repeat (400) begin
      if ($urandom_range(3) == 0) begin
        n = $urandom_range(NCH - 1);
        if (drv_q[n].size() < 12) gen_block(int'(n), int'($urandom_range(7, 1)));
      end
      valid_pct = 70;
      TX_AFULL = ($urandom_range(4) == 0);
      ENABLE = ($urandom_range(9) != 0);
      if ($urandom_range(15) == 0) CH_MASK = 4'($urandom_range(15));
      cycle();
    end
    drain(2000);

    // ENABLE and CH_MASK dropped mid-frame
    gen_block(0, 4);
    gen_block(1, 2);
    wait_phase(1, 0, 30, "p6_start");
    ENABLE = 1'b0;
    CH_MASK = '0;
    n = 0;
    while (!after_trl && n < 20) begin
      cycle();
      n++;
    end
    chk("p6_trl_seen", 68'(after_trl), 68'(1));
    repeat (15) begin
      cycle();
      chk("p6_no_hdr", 68'(TX_B), 68'(0));
    end
    chk("p6_pending", 68'(idle_now()), 68'(0));
    drain(100);

    // Reset pulsed mid-frame
    gen_block(2, 3);
    wait_phase(1, 0, 30, "p7_start");
    RST_N = 1'b0;
    #1;
    chk("p7_txb", 68'(TX_B), 68'(0));
    chk("p7_txd", 68'(TX_D), 68'(0));
    chk("p7_ready", 68'(CH_READY), 68'(0));
    chk("p7_blk", 68'(BLK_CNT), 68'(0));
    chk("p7_trunc", 68'(TRUNC_CNT), 68'(0));
    reset_model();
    repeat (3) cycle();
    RST_N = 1'b1;
    hdr_log.delete();
    drain(50);
    chk("p7_hdr_count", 68'(hdr_log.size()), 68'(1));
    if (hdr_log.size() >= 1) begin
      chk("p7_hdr", 68'(hdr_log[0]), 68'(64'hA55A_0200_0000_0000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcp_tx_merge.md
# tcp_tx_merge

Merges NUM_CH independent 64-bit readout streams into the single SiTCPXG TCP transmit port (USER_TX_D / USER_TX_B / USER_TX_AFULL) in the 156.25 MHz SiTCPXG clock domain. Each input block is wrapped in a header/trailer frame that carries the channel ID, a per-channel sequence number and the word count. This block succeeds the single-source TCP test path: arbitration is round-robin and parametrised in channel count and maximum block length, blocks are truncated at the limit, and SiTCPXG almost-full backpressure is honoured.

## Interface
- NUM_CH, 4: number of input channels, 1..256.
- MAX_BLK_WORDS, 1024: maximum number of data words per frame, 1..65535.
- CLK  in  1  SiTCPXG user clock (CLKOUT, 156.25 MHz). One clock.
- RST_N  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  permits new frames to start. A frame already in progress always completes.
- CH_MASK  in  NUM_CH  per-channel enable. Sampled only in IDLE.
- CH_VALID  in  NUM_CH  channel data word valid.
- CH_READY  out  NUM_CH  channel word accepted when VALID and READY are both high.
- CH_DATA  in  NUM_CH*64  channel data; channel i occupies [64i+63:64i].
- CH_LAST  in  NUM_CH  marks the last word of a channel block.
- TX_AFULL  in  1  SiTCPXG transmit FIFO almost full.
- TX_D  out  64  to USER_TX_D.
- TX_B  out  4  to USER_TX_B: 8 = valid word, 0 = idle.
- BLK_CNT  out  32  frames completed, wraps modulo 2^32.
- TRUNC_CNT  out  16  frames truncated at MAX_BLK_WORDS, saturates at 0xFFFF.

## Operation
- State machine: IDLE → HDR → DATA → TRL → IDLE.
- **IDLE:** a grant is issued when ENABLE=1, TX_AFULL=0 and (CH_VALID & CH_MASK) ≠ 0.
  - Round-robin: the search starts at the channel after the last one granted (after reset, channel 0 is searched first).
  - The granted channel is latched in `sel`; next state is HDR.
- **HDR:** emits the header {16'hA55A, ch[7:0], 8'h00, seq[sel][31:0]}.
  - If TX_AFULL=1, the header is held (TX_B=0) until TX_AFULL=0.
  - Next state is DATA.
- **DATA:** CH_READY[sel] = ~TX_AFULL. All other CH_READY bits are 0.
  - Each handshake copies CH_DATA[sel] to TX_D with TX_B=8 and increments `wcnt`.
  - Leave for TRL on a handshake with CH_LAST=1, or when `wcnt` reaches MAX_BLK_WORDS (sets the `trunc` flag).
- **TRL:** emits the trailer {16'h5AA5, ch[7:0], 7'b0, trunc, 16'h0000, wcnt[15:0]}. Held while TX_AFULL=1.
  - On emission: seq[sel] += 1 (wraps), BLK_CNT += 1, TRUNC_CNT += trunc (saturating).
  - Clear `wcnt` and `trunc`; next state is IDLE.
- **Truncation:** after a truncated frame, the remaining words of that channel block form a new frame on a later grant, with the next sequence number.
- **Configuration changes:**
  - ENABLE falling or a CH_MASK change mid-frame has no effect until IDLE.
  - Masking a channel mid-frame does not abort the frame.
- **Reset values** (RST_N low, any time including mid-frame):
  - Outputs: TX_D=0, TX_B=0, CH_READY=0, BLK_CNT=0, TRUNC_CNT=0.
  - Internal: all seq=0, state=IDLE, rr pointer=0.
  - No partial trailer is emitted.

## Timing
- All outputs except CH_READY are registered. CH_READY is combinational from state, `sel` and TX_AFULL.
- Grant at edge t → header on TX_D at t+1 when TX_AFULL=0.
- A handshake in cycle c → the word appears on TX_D in cycle c+1.
- Trailer appears in the cycle after the last data word, unless TX_AFULL=1.
- Exactly one TX_B=0 IDLE cycle follows every trailer.
- Minimum frame: header, 1 data word, trailer in 3 consecutive cycles, then 1 idle cycle.
- TX_AFULL is acted on in the same cycle it is seen. While it is high, TX_B=0 from the next cycle on. SiTCPXG's almost-full slack absorbs the one-word skid.
- Widths:
  - `wcnt`: $clog2(MAX_BLK_WORDS+1) bits, zero-extended to 16 in the trailer.
  - Channel ID: zero-extended to 8 bits.
  - seq: 32 bits per channel, stored in registers (NUM_CH×32 flops).

## Structure
- Package tcp_tx_merge_pkg holds:
  - HDR_MAGIC = 16'hA55A and TRL_MAGIC = 16'h5AA5;
  - the state encoding (IDLE, HDR, DATA, TRL);
  - the TX_B_FULL = 4'd8 constant.
- One sub-module, rr_arbiter #(N): request vector, enable and advance strobe in; one-hot grant and binary index out; holds the priority pointer.

## Test plan
- **Single channel:** NUM_CH=4, channel 2 sends 3 words (last on word 3), TX_AFULL=0 → TX_D sequence A55A_02_00_00000000, w0, w1, w2, 5AA5_02_00_0000_0003; BLK_CNT=1; then one idle cycle.
- **Round-robin fairness:** all 4 channels valid continuously with 1-word blocks → header channel order 0,1,2,3,0,…; each seq increments by 1 per frame.
- **Truncation:** MAX_BLK_WORDS=4, channel 1 sends a 6-word block → first trailer trunc=1, wcnt=4; second frame seq=1, wcnt=2, trunc=0; TRUNC_CNT=1.
- **Backpressure:** TX_AFULL held high for 10 cycles mid-DATA → TX_B=0 and CH_READY=0 throughout; no word lost or duplicated; frame completes after release.
- **Control changes:** ENABLE dropped and CH_MASK cleared mid-frame → the current frame completes with its trailer, and no new header is issued. RST_N pulsed low mid-frame → TX_B=0 immediately, all counters 0; the next frame for that channel has seq=0.
